// File: rtl/cl_pkg.sv
// Shared definitions for the N-bit logic cell: op codes, op width and the
// result-register state type.
package cl_pkg;

  localparam int CL_OP_W = 3;

  // Codes 0..3 keep the order of the legacy 2-bit cell.
  localparam logic [CL_OP_W-1:0] CL_AND  = 3'd0;
  localparam logic [CL_OP_W-1:0] CL_OR   = 3'd1;
  localparam logic [CL_OP_W-1:0] CL_XOR  = 3'd2;
  localparam logic [CL_OP_W-1:0] CL_NOTA = 3'd3;
  localparam logic [CL_OP_W-1:0] CL_NAND = 3'd4;
  localparam logic [CL_OP_W-1:0] CL_NOR  = 3'd5;
  localparam logic [CL_OP_W-1:0] CL_XNOR = 3'd6;
  localparam logic [CL_OP_W-1:0] CL_PASS = 3'd7;

  typedef enum logic {
    CL_EMPTY = 1'b0,
    CL_FULL  = 1'b1
  } cl_state_e;

endpackage

// File: rtl/cl_vec_n.sv
// Combinational WIDTH-bit logic slice: y = f(a, b) for the selected op,
// built from one identical cell per bit.
module cl_vec_n
  import cl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [CL_OP_W-1:0] op_i,
  output logic [WIDTH-1:0]   y_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic y_bit;

    always_comb begin
      y_bit = a_i[i];
      case (op_i)
        CL_AND:  y_bit = a_i[i] & b_i[i];
        CL_OR:   y_bit = a_i[i] | b_i[i];
        CL_XOR:  y_bit = a_i[i] ^ b_i[i];
        CL_NOTA: y_bit = ~a_i[i];
        CL_NAND: y_bit = ~(a_i[i] & b_i[i]);
        CL_NOR:  y_bit = ~(a_i[i] | b_i[i]);
        CL_XNOR: y_bit = ~(a_i[i] ^ b_i[i]);
        default: y_bit = a_i[i];
      endcase
    end

    assign y_o[i] = y_bit;
  end

endmodule

// File: rtl/cl_seq_n.sv
// Registered N-bit logic cell with valid/ready handshake, accumulate mode and
// op counter. Define CL_FLAGS_EN to add the registered zero/parity flags.
module cl_seq_n
  import cl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [CL_OP_W-1:0]   op,
  input  logic                 acc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic [CNT_WIDTH-1:0] op_count
`ifdef CL_FLAGS_EN
  ,
  output logic                 zero,
  output logic                 parity
`endif
);

  // Handshake: a transfer happens at a rising edge where valid && ready; ready
  // never depends on valid, and a full register being drained accepts at once.

  cl_state_e            state_q, state_d;
  logic [WIDTH-1:0]     a_sel, y;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept;

  assign a_sel = acc ? acc_q : a;

  cl_vec_n #(.WIDTH(WIDTH)) u_vec (
    .a_i  (a_sel),
    .b_i  (b),
    .op_i (op),
    .y_o  (y)
  );

  assign out_valid = (state_q == CL_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign result    = result_q;
  assign op_count  = cnt_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (accept) begin
      state_d  = CL_FULL;
      result_d = y;
      acc_d    = y;
      cnt_d    = cnt_q + CNT_WIDTH'(1);
    end else if (out_valid && out_ready) begin
      state_d = CL_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= CL_EMPTY;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef CL_FLAGS_EN
  logic zero_q, parity_q;

  // Flags track result, so they reset to the values matching result == 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
    end else if (accept) begin
      zero_q   <= (y == '0);
      parity_q <= ^y;
    end
  end

  assign zero   = zero_q;
  assign parity = parity_q;
`endif

endmodule
